// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic matrix-multiply tile.
package systolic_pkg;

    localparam int unsigned DEF_ROWS   = 4;
    localparam int unsigned DEF_COLS   = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_K_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } tile_state_e;

endpackage

// File: rtl/systolic_tile_if.sv
// Job control, operand stream and result handshake of the systolic tile.
interface systolic_tile_if
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned K_W    = DEF_K_W
);
    logic                                  start;
    logic [K_W-1:0]                        k_len;
    logic                                  signed_mode;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [ROWS-1:0][DATA_W-1:0]           a_in;
    logic [COLS-1:0][DATA_W-1:0]           b_in;
    logic                                  busy;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  c_out;

    modport master (
        output start, k_len, signed_mode, in_valid, a_in, b_in, out_ready,
        input  in_ready, busy, out_valid, c_out
    );

    modport slave (
        input  start, k_len, signed_mode, in_valid, a_in, b_in, out_ready,
        output in_ready, busy, out_valid, c_out
    );
endinterface

// File: rtl/tile_pe.sv
// Output-stationary processing element: forwards operands right/down and
// accumulates their product whenever both arrive together.
module tile_pe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vin,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vin,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vout,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vout,
    output logic [ACC_W-1:0]  acc
);
    localparam int unsigned PROD_W = 2 * DATA_W + 2;

    logic signed [DATA_W:0]   a_ext;
    logic signed [DATA_W:0]   b_ext;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_acc;

    // One extra operand bit makes a single signed multiplier serve both modes.
    always_comb begin
        a_ext    = {signed_mode & a_in[DATA_W-1], a_in};
        b_ext    = {signed_mode & b_in[DATA_W-1], b_in};
        prod     = PROD_W'(a_ext) * PROD_W'(b_ext);
        prod_acc = ACC_W'(prod);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out  <= '0;
            a_vout <= 1'b0;
            b_out  <= '0;
            b_vout <= 1'b0;
            acc    <= '0;
        end else if (clear) begin
            a_out  <= '0;
            a_vout <= 1'b0;
            b_out  <= '0;
            b_vout <= 1'b0;
            acc    <= '0;
        end else begin
            a_out  <= a_in;
            a_vout <= a_vin;
            b_out  <= b_in;
            b_vout <= b_vin;
            if (a_vin && b_vin) begin
                acc <= acc + prod_acc;
            end
        end
    end
endmodule

// File: rtl/systolic_tile.sv
// ROWS x COLS output-stationary systolic tile computing C = A*B over k_len
// streamed beats (column k of A, row k of B per beat).
module systolic_tile
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned K_W    = DEF_K_W
) (
    input  logic            clk,
    input  logic            reset,
    systolic_tile_if.slave  bus
);
    localparam int unsigned LANE_W     = DATA_W + 1;
    localparam int unsigned FL_W       = $clog2(ROWS + COLS);
    localparam int unsigned FLUSH_LAST = ROWS + COLS - 2;

    tile_state_e    state_q, state_d;
    logic [K_W-1:0] k_len_q, k_len_d;
    logic [K_W-1:0] beat_q, beat_d;
    logic [FL_W-1:0] flush_q, flush_d;
    logic           signed_q, signed_d;
    logic           clear_c, capture_c, beat_ok_c;

    logic           in_ready_q, busy_q, out_valid_q;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] acc, c_out_q;

    // Operand mesh: column COLS / row ROWS are the outputs leaving the array.
    logic [ROWS-1:0][COLS:0][DATA_W-1:0] a_h;
    logic [ROWS-1:0][COLS:0]             a_hv;
    logic [ROWS:0][COLS-1:0][DATA_W-1:0] b_v;
    logic [ROWS:0][COLS-1:0]             b_vv;

    // Next-state and job bookkeeping.
    always_comb begin
        state_d   = state_q;
        k_len_d   = k_len_q;
        signed_d  = signed_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        clear_c   = 1'b0;
        capture_c = 1'b0;
        beat_ok_c = (state_q == ST_LOAD) && bus.in_valid;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear_c  = 1'b1;
                    k_len_d  = bus.k_len;
                    signed_d = bus.signed_mode;
                    beat_d   = '0;
                    state_d  = (bus.k_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_ok_c) begin
                    beat_d = beat_q + K_W'(1);
                    if (beat_q == k_len_q - K_W'(1)) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                // Drain edges for the far PE, then one edge to capture the result.
                flush_d = flush_q + FL_W'(1);
                if (flush_q == FL_W'(FLUSH_LAST)) begin
                    state_d   = ST_DONE;
                    capture_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            signed_q    <= 1'b0;
            beat_q      <= '0;
            flush_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            c_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            signed_q    <= signed_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            in_ready_q  <= (state_d == ST_LOAD);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            if (clear_c) begin
                c_out_q <= '0;
            end else if (capture_c) begin
                c_out_q <= acc;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c_out     = c_out_q;

    // Row i of A enters i cycles late so it meets column j of B at PE(i,j).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_h[i][0]  = bus.a_in[i];
            assign a_hv[i][0] = beat_ok_c;
        end else begin : g_shift
            logic [LANE_W-1:0] pipe [i];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe <= '{default: '0};
                end else if (clear_c) begin
                    pipe <= '{default: '0};
                end else begin
                    pipe[0] <= {beat_ok_c, bus.a_in[i]};
                    for (int d = 1; d < i; d++) begin
                        pipe[d] <= pipe[d-1];
                    end
                end
            end
            assign {a_hv[i][0], a_h[i][0]} = pipe[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_v[0][j]  = bus.b_in[j];
            assign b_vv[0][j] = beat_ok_c;
        end else begin : g_shift
            logic [LANE_W-1:0] pipe [j];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe <= '{default: '0};
                end else if (clear_c) begin
                    pipe <= '{default: '0};
                end else begin
                    pipe[0] <= {beat_ok_c, bus.b_in[j]};
                    for (int d = 1; d < j; d++) begin
                        pipe[d] <= pipe[d-1];
                    end
                end
            end
            assign {b_vv[0][j], b_v[0][j]} = pipe[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            tile_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk         (clk),
                .reset       (reset),
                .clear       (clear_c),
                .signed_mode (signed_q),
                .a_in        (a_h[i][j]),
                .a_vin       (a_hv[i][j]),
                .b_in        (b_v[i][j]),
                .b_vin       (b_vv[i][j]),
                .a_out       (a_h[i][j+1]),
                .a_vout      (a_hv[i][j+1]),
                .b_out       (b_v[i+1][j]),
                .b_vout      (b_vv[i+1][j]),
                .acc         (acc[i][j])
            );
        end
    end

    // Operands leaving the mesh edge have no consumer.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < int'(ROWS); i++) begin
            unused_edge = unused_edge ^ a_hv[i][COLS] ^ (^a_h[i][COLS]);
        end
        for (int j = 0; j < int'(COLS); j++) begin
            unused_edge = unused_edge ^ b_vv[ROWS][j] ^ (^b_v[ROWS][j]);
        end
    end
endmodule

// File: tb/tb_systolic_tile.sv
// Scoreboard bench for systolic_tile: a 2x2 narrow-accumulator instance and a
// 4x4 default instance share one driver selected by sel_big.
module tb_systolic_tile;
    localparam int unsigned S_ROWS = 2, S_COLS = 2, S_DW = 8, S_AW = 16, S_KW = 17;
    localparam int unsigned B_ROWS = 4, B_COLS = 4, B_DW = 8, B_AW = 32, B_KW = 16;
    localparam int unsigned CW = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic                       sel_big = 1'b0;
    logic                       drv_start = 1'b0;
    logic [31:0]                drv_k = '0;
    logic                       drv_sm = 1'b0;
    logic                       drv_valid = 1'b0;
    logic                       drv_ready = 1'b0;
    logic [B_ROWS*B_DW-1:0]     drv_a = '0;
    logic [B_COLS*B_DW-1:0]     drv_b = '0;

    logic                       mon_ready, mon_busy, mon_valid;
    logic [CW-1:0]              mon_c;

    logic [CW-1:0]              sb[$];

    systolic_tile_if #(.ROWS(S_ROWS), .COLS(S_COLS), .DATA_W(S_DW), .ACC_W(S_AW), .K_W(S_KW)) s_if ();
    systolic_tile_if #(.ROWS(B_ROWS), .COLS(B_COLS), .DATA_W(B_DW), .ACC_W(B_AW), .K_W(B_KW)) b_if ();

    assign s_if.start       = drv_start & ~sel_big;
    assign s_if.k_len       = drv_k[S_KW-1:0];
    assign s_if.signed_mode = drv_sm;
    assign s_if.in_valid    = drv_valid & ~sel_big;
    assign s_if.a_in        = drv_a[S_ROWS*S_DW-1:0];
    assign s_if.b_in        = drv_b[S_COLS*S_DW-1:0];
    assign s_if.out_ready   = drv_ready & ~sel_big;

    assign b_if.start       = drv_start & sel_big;
    assign b_if.k_len       = drv_k[B_KW-1:0];
    assign b_if.signed_mode = drv_sm;
    assign b_if.in_valid    = drv_valid & sel_big;
    assign b_if.a_in        = drv_a;
    assign b_if.b_in        = drv_b;
    assign b_if.out_ready   = drv_ready & sel_big;

    assign mon_ready = sel_big ? b_if.in_ready  : s_if.in_ready;
    assign mon_busy  = sel_big ? b_if.busy      : s_if.busy;
    assign mon_valid = sel_big ? b_if.out_valid : s_if.out_valid;
    assign mon_c     = sel_big ? CW'(b_if.c_out) : CW'(s_if.c_out);

    systolic_tile #(.ROWS(S_ROWS), .COLS(S_COLS), .DATA_W(S_DW), .ACC_W(S_AW), .K_W(S_KW)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    systolic_tile #(.ROWS(B_ROWS), .COLS(B_COLS), .DATA_W(B_DW), .ACC_W(B_AW), .K_W(B_KW)) u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ext(input int v, input int dw, input bit sm);
        longint x;
        x = longint'(v) & ((longint'(1) << dw) - 1);
        if (sm && x[dw-1]) x = x - (longint'(1) << dw);
        return x;
    endfunction

    // Reference matrix product, wrapped to aw bits, packed like c_out.
    function automatic logic [CW-1:0] model(input int rows, input int cols, input int aw,
                                            input bit sm, input int k,
                                            input int a_q[$], input int b_q[$]);
        logic [CW-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < rows; i++) begin
            for (int j = 0; j < cols; j++) begin
                s = 0;
                for (int t = 0; t < k; t++) begin
                    s = s + ext(a_q[t*rows+i], 8, sm) * ext(b_q[t*cols+j], 8, sm);
                end
                for (int t = 0; t < aw; t++) begin
                    r[(i*cols+j)*aw+t] = s[t];
                end
            end
        end
        return r;
    endfunction

    task automatic run_job(input bit big, input int k, input bit sm, input bit gaps,
                           input int a_q[$], input int b_q[$], input int hold);
        int rows, cols, aw, idx, cyc, lat, exp_lat;
        bit rdy_bad;
        logic [CW-1:0] exp;
        rows = big ? B_ROWS : S_ROWS;
        cols = big ? B_COLS : S_COLS;
        aw   = big ? B_AW : S_AW;
        exp_lat = (k == 0) ? 0 : rows + cols - 1;
        sel_big = big;
        sb.push_back(model(rows, cols, aw, sm, k, a_q, b_q));

        @(posedge clk); #1;
        drv_k = 32'(k); drv_sm = sm; drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;

        idx = 0; cyc = 0; rdy_bad = 1'b0;
        while (idx < k && cyc < 2*k + 20) begin
            drv_valid = !(gaps && cyc[0]);
            for (int i = 0; i < rows; i++) drv_a[i*8 +: 8] = 8'(a_q[idx*rows+i]);
            for (int j = 0; j < cols; j++) drv_b[j*8 +: 8] = 8'(b_q[idx*cols+j]);
            if (drv_valid && mon_ready) begin
                @(posedge clk); #1;
                idx++;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        drv_valid = 1'b0;
        check("beats_accepted", 32'(idx), 32'(k));

        lat = 0;
        while (!mon_valid && lat < 64) begin
            if (mon_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("out_latency", 32'(lat), 32'(exp_lat));
        exp = sb.pop_front();
        check("c_out", mon_c, exp);

        for (int h = 0; h < hold; h++) begin
            if (mon_ready) rdy_bad = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", CW'(mon_valid), CW'(1'b1));
            check("hold_c_out", mon_c, exp);
        end

        // start together with out_ready must only finish the handshake
        drv_ready = 1'b1; drv_start = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0; drv_start = 1'b0;
        check("valid_fall", CW'(mon_valid), '0);
        @(posedge clk); #1;
        check("idle_busy", CW'(mon_busy), '0);
        check("idle_c_hold", mon_c, exp);
        check("in_ready_outside_load", CW'(rdy_bad), '0);
    endtask

    int a_q[$], b_q[$];
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", CW'(s_if.in_ready), '0);
        check("rst_busy", CW'(s_if.busy), '0);
        check("rst_valid", CW'(s_if.out_valid), '0);
        check("rst_c_small", CW'(s_if.c_out), '0);
        check("rst_c_big", CW'(b_if.c_out), '0);
        #3 reset = 1'b0;

        // 2x2 unsigned reference product
        a_q.delete(); b_q.delete();
        a_q.push_back(1); a_q.push_back(3); a_q.push_back(2); a_q.push_back(4);
        b_q.push_back(5); b_q.push_back(6); b_q.push_back(7); b_q.push_back(8);
        run_job(1'b0, 2, 1'b0, 1'b0, a_q, b_q, 0);

        // same k=3 data with and without in_valid gaps
        a_q.delete(); b_q.delete();
        for (int t = 0; t < 6; t++) begin
            a_q.push_back(int'($urandom_range(0, 255)));
            b_q.push_back(int'($urandom_range(0, 255)));
        end
        run_job(1'b0, 3, 1'b0, 1'b1, a_q, b_q, 0);
        run_job(1'b0, 3, 1'b0, 1'b0, a_q, b_q, 0);

        // signed random job, narrow accumulator wraps
        a_q.delete(); b_q.delete();
        for (int t = 0; t < 10; t++) begin
            a_q.push_back(int'($urandom_range(0, 255)));
            b_q.push_back(int'($urandom_range(0, 255)));
        end
        run_job(1'b0, 5, 1'b1, 1'b1, a_q, b_q, 0);

        // empty job goes straight to DONE and holds
        a_q.delete(); b_q.delete();
        run_job(1'b0, 0, 1'b0, 1'b0, a_q, b_q, 5);

        // reset while flushing abandons the job
        sel_big = 1'b0;
        @(posedge clk); #1;
        drv_k = 32'd2; drv_sm = 1'b0; drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0; drv_valid = 1'b1;
        drv_a = 32'h0000_0301; drv_b = 32'h0000_0605;
        @(posedge clk); #1;
        drv_a = 32'h0000_0402; drv_b = 32'h0000_0807;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        check("flush_busy", CW'(mon_busy), CW'(1'b1));
        #2 reset = 1'b1;
        #1;
        check("arst_ready", CW'(mon_ready), '0);
        check("arst_busy", CW'(mon_busy), '0);
        check("arst_valid", CW'(mon_valid), '0);
        check("arst_c_out", mon_c, '0);
        #1 reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mon_valid) seen = 1'b1;
        end
        check("no_valid_after_reset", CW'(seen), '0);
        a_q.delete(); b_q.delete();
        a_q.push_back(1); a_q.push_back(3); a_q.push_back(2); a_q.push_back(4);
        b_q.push_back(5); b_q.push_back(6); b_q.push_back(7); b_q.push_back(8);
        run_job(1'b0, 2, 1'b0, 1'b0, a_q, b_q, 0);

        // 4x4 signed: A = all -1, B = identity
        a_q.delete(); b_q.delete();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) a_q.push_back(255);
            for (int j = 0; j < 4; j++) b_q.push_back((j == t) ? 1 : 0);
        end
        run_job(1'b1, 4, 1'b1, 1'b0, a_q, b_q, 2);

        // 4x4 signed random with gaps
        a_q.delete(); b_q.delete();
        for (int t = 0; t < 24; t++) begin
            a_q.push_back(int'($urandom_range(0, 255)));
            b_q.push_back(int'($urandom_range(0, 255)));
        end
        run_job(1'b1, 6, 1'b1, 1'b1, a_q, b_q, 0);

        // long unsigned run wraps the 16-bit accumulator
        a_q.delete(); b_q.delete();
        for (int t = 0; t < 70000; t++) begin
            a_q.push_back(255); a_q.push_back(255);
            b_q.push_back(255); b_q.push_back(255);
        end
        run_job(1'b0, 70000, 1'b0, 1'b0, a_q, b_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
